wb_port_arbiter: RTL and testbench

//  Shares two registered writeback/wakeup ports among four function units: ALU0=0, ALU1=1, BU=2, DU=3.

---
 rtl/wb_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Two-port round-robin writeback/wakeup arbiter for four function units (ALU0, ALU1, BU, DU).
// Optional early-wake outputs are enabled by defining WB_EARLY_WAKE_EN.
module wb_port_arbiter #(
    parameter int PHY_W  = 6,
    parameter int WIN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                wb_stall_i,
    input  logic [3:0]          req_valid_i,
    input  logic [4*PHY_W-1:0]  req_phy_i,
    input  logic [4*WIN_W-1:0]  req_win_i,
    input  logic [4*DATA_W-1:0] req_data_i,
    output logic [3:0]          req_ready_o,
`ifdef WB_EARLY_WAKE_EN
    output logic                ew0_valid_o,
    output logic [PHY_W-1:0]    ew0_phy_o,
    output logic                ew1_valid_o,
    output logic [PHY_W-1:0]    ew1_phy_o,
`endif
    output logic                wb0_valid_o,
    output logic [1:0]          wb0_src_o,
    output logic [PHY_W-1:0]    wb0_phy_o,
    output logic [WIN_W-1:0]    wb0_win_o,
    output logic [DATA_W-1:0]   wb0_data_o,
    output logic                wb1_valid_o,
    output logic [1:0]          wb1_src_o,
    output logic [PHY_W-1:0]    wb1_phy_o,
    output logic [WIN_W-1:0]    wb1_win_o,
    output logic [DATA_W-1:0]   wb1_data_o
);

    logic              grant_en;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              g0_vld, g1_vld;
    logic [1:0]        g0_id, g1_id;
    logic [1:0]        scan_idx;

    logic [PHY_W-1:0]  g0_phy, g1_phy;
    logic [WIN_W-1:0]  g0_win, g1_win;
    logic [DATA_W-1:0] g0_data, g1_data;

    logic              wb0_valid_q, wb1_valid_q;
    logic [1:0]        wb0_src_q, wb1_src_q;
    logic [PHY_W-1:0]  wb0_phy_q, wb1_phy_q;
    logic [WIN_W-1:0]  wb0_win_q, wb1_win_q;
    logic [DATA_W-1:0] wb0_data_q, wb1_data_q;

    assign grant_en = !(wb_stall_i || flush_i || rst_i);

    // Scan ptr, ptr+1, ptr+2, ptr+3: first valid -> port0, second -> port1.
    always_comb begin
        g0_vld   = 1'b0;
        g0_id    = 2'd0;
        g1_vld   = 1'b0;
        g1_id    = 2'd0;
        scan_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + k[1:0];
            if (grant_en && req_valid_i[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_id  = scan_idx;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_id  = scan_idx;
                end
            end
        end
    end

    always_comb begin
        req_ready_o = 4'b0000;
        if (g0_vld) req_ready_o[g0_id] = 1'b1;
        if (g1_vld) req_ready_o[g1_id] = 1'b1;

        rr_ptr_d = rr_ptr_q;
        if (g1_vld)      rr_ptr_d = g1_id + 2'd1;
        else if (g0_vld) rr_ptr_d = g0_id + 2'd1;
    end

    // Ungranted ports carry all-zero fields.
    always_comb begin
        g0_phy  = g0_vld ? req_phy_i [int'(g0_id)*PHY_W  +: PHY_W]  : '0;
        g0_win  = g0_vld ? req_win_i [int'(g0_id)*WIN_W  +: WIN_W]  : '0;
        g0_data = g0_vld ? req_data_i[int'(g0_id)*DATA_W +: DATA_W] : '0;
        g1_phy  = g1_vld ? req_phy_i [int'(g1_id)*PHY_W  +: PHY_W]  : '0;
        g1_win  = g1_vld ? req_win_i [int'(g1_id)*WIN_W  +: WIN_W]  : '0;
        g1_data = g1_vld ? req_data_i[int'(g1_id)*DATA_W +: DATA_W] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_ptr_q    <= 2'd0;
            wb0_valid_q <= 1'b0;
            wb0_src_q   <= 2'd0;
            wb0_phy_q   <= '0;
            wb0_win_q   <= '0;
            wb0_data_q  <= '0;
            wb1_valid_q <= 1'b0;
            wb1_src_q   <= 2'd0;
            wb1_phy_q   <= '0;
            wb1_win_q   <= '0;
            wb1_data_q  <= '0;
        end else if (!wb_stall_i) begin
            rr_ptr_q    <= rr_ptr_d;
            wb0_valid_q <= g0_vld;
            wb0_src_q   <= g0_vld ? g0_id : 2'd0;
            wb0_phy_q   <= g0_phy;
            wb0_win_q   <= g0_win;
            wb0_data_q  <= g0_data;
            wb1_valid_q <= g1_vld;
            wb1_src_q   <= g1_vld ? g1_id : 2'd0;
            wb1_phy_q   <= g1_phy;
            wb1_win_q   <= g1_win;
            wb1_data_q  <= g1_data;
        end
    end

    assign wb0_valid_o = wb0_valid_q;
    assign wb0_src_o   = wb0_src_q;
    assign wb0_phy_o   = wb0_phy_q;
    assign wb0_win_o   = wb0_win_q;
    assign wb0_data_o  = wb0_data_q;
    assign wb1_valid_o = wb1_valid_q;
    assign wb1_src_o   = wb1_src_q;
    assign wb1_phy_o   = wb1_phy_q;
    assign wb1_win_o   = wb1_win_q;
    assign wb1_data_o  = wb1_data_q;

`ifdef WB_EARLY_WAKE_EN
    // Grant-cycle tags; grant_en already forces these low under stall/flush/reset.
    assign ew0_valid_o = g0_vld;
    assign ew0_phy_o   = g0_phy;
    assign ew1_valid_o = g1_vld;
    assign ew1_phy_o   = g1_phy;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, rotation, single requester, stall hold, flush, early wake.
module tb_wb_port_arbiter;

    localparam int PHY_W  = 6;
    localparam int WIN_W  = 4;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst, flush, wb_stall;
    logic [3:0]          req_valid;
    logic [4*PHY_W-1:0]  req_phy;
    logic [4*WIN_W-1:0]  req_win;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                wb0_valid, wb1_valid;
    logic [1:0]          wb0_src, wb1_src;
    logic [PHY_W-1:0]    wb0_phy, wb1_phy;
    logic [WIN_W-1:0]    wb0_win, wb1_win;
    logic [DATA_W-1:0]   wb0_data, wb1_data;
`ifdef WB_EARLY_WAKE_EN
    logic                ew0_valid, ew1_valid;
    logic [PHY_W-1:0]    ew0_phy, ew1_phy;
`endif

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.PHY_W(PHY_W), .WIN_W(WIN_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .wb_stall_i  (wb_stall),
        .req_valid_i (req_valid),
        .req_phy_i   (req_phy),
        .req_win_i   (req_win),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
`ifdef WB_EARLY_WAKE_EN
        .ew0_valid_o (ew0_valid),
        .ew0_phy_o   (ew0_phy),
        .ew1_valid_o (ew1_valid),
        .ew1_phy_o   (ew1_phy),
`endif
        .wb0_valid_o (wb0_valid),
        .wb0_src_o   (wb0_src),
        .wb0_phy_o   (wb0_phy),
        .wb0_win_o   (wb0_win),
        .wb0_data_o  (wb0_data),
        .wb1_valid_o (wb1_valid),
        .wb1_src_o   (wb1_src),
        .wb1_phy_o   (wb1_phy),
        .wb1_win_o   (wb1_win),
        .wb1_data_o  (wb1_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ports(input string tag,
                             input logic v0, input logic [1:0] s0, input logic [31:0] d0,
                             input logic v1, input logic [1:0] s1, input logic [31:0] d1);
        chk({tag, ".wb0_valid"}, 64'(wb0_valid), 64'(v0));
        chk({tag, ".wb0_src"},   64'(wb0_src),   64'(s0));
        chk({tag, ".wb0_data"},  64'(wb0_data),  64'(d0));
        chk({tag, ".wb1_valid"}, 64'(wb1_valid), 64'(v1));
        chk({tag, ".wb1_src"},   64'(wb1_src),   64'(s1));
        chk({tag, ".wb1_data"},  64'(wb1_data),  64'(d1));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wb_stall = 1'b0;
        req_valid = 4'b1111;
        // Requester i: phy = 10+i, win = 4+i, data = 0x1000+i.
        for (int i = 0; i < 4; i++) begin
            req_phy [i*PHY_W  +: PHY_W]  = PHY_W'(10 + i);
            req_win [i*WIN_W  +: WIN_W]  = WIN_W'(4 + i);
            req_data[i*DATA_W +: DATA_W] = 32'h1000 + 32'(i);
        end

        // Reset held two cycles with all valid.
        tick();
        chk("rst1.ready", 64'(req_ready), 64'b0000);
        chk_ports("rst1", 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0);
        tick();
        chk("rst2.ready", 64'(req_ready), 64'b0000);
        rst = 1'b0;
        #1;
        chk_ports("postrst", 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0);
        chk("rr.c1.ready", 64'(req_ready), 64'b0011);

        // Rotation with all four valid.
        tick();
        chk_ports("rr.e1", 1'b1, 2'd0, 32'h1000, 1'b1, 2'd1, 32'h1001);
        chk("rr.e1.wb0_phy", 64'(wb0_phy), 64'd10);
        chk("rr.e1.wb1_win", 64'(wb1_win), 64'd5);
        chk("rr.c2.ready", 64'(req_ready), 64'b1100);
        tick();
        chk_ports("rr.e2", 1'b1, 2'd2, 32'h1002, 1'b1, 2'd3, 32'h1003);
        chk("rr.c3.ready", 64'(req_ready), 64'b0011);

        // Stall three cycles: outputs held, no grants, pointer frozen at 0.
        wb_stall = 1'b1;
        #1;
        chk("stall.ready", 64'(req_ready), 64'b0000);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stall.ready_c", 64'(req_ready), 64'b0000);
            chk_ports("stall.hold", 1'b1, 2'd2, 32'h1002, 1'b1, 2'd3, 32'h1003);
        end
        wb_stall = 1'b0;
        #1;
        chk("unstall.ready", 64'(req_ready), 64'b0011);
        tick();
        chk_ports("unstall.e", 1'b1, 2'd0, 32'h1000, 1'b1, 2'd1, 32'h1001);

        // Only DU valid, pointer at 2.
        req_valid = 4'b1000;
        req_phy [3*PHY_W  +: PHY_W]  = 6'h2A;
        req_win [3*WIN_W  +: WIN_W]  = 4'h9;
        req_data[3*DATA_W +: DATA_W] = 32'hDEADBEEF;
        #1;
        chk("du.ready", 64'(req_ready), 64'b1000);
        tick();
        chk_ports("du.e", 1'b1, 2'd3, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0);
        chk("du.wb0_phy", 64'(wb0_phy), 64'h2A);
        chk("du.wb0_win", 64'(wb0_win), 64'h9);
        chk("du.wb1_phy", 64'(wb1_phy), 64'h0);
        chk("du.wb1_win", 64'(wb1_win), 64'h0);

        // Single ALU0 grant with tag 0 moves the pointer to 1.
        req_valid = 4'b0001;
        req_phy[0 +: PHY_W] = 6'h00;
        #1;
        chk("alu0.ready", 64'(req_ready), 64'b0001);
        tick();
        chk_ports("alu0.e", 1'b1, 2'd0, 32'h1000, 1'b0, 2'd0, 32'h0);
        chk("alu0.wb0_phy", 64'(wb0_phy), 64'h0);

        // Flush with ptr=1: clears outputs and pointer; ptr=1 would order 2 before 0.
        req_valid = 4'b0101;
        flush = 1'b1;
        #1;
        chk("flush.ready", 64'(req_ready), 64'b0000);
        tick();
        flush = 1'b0;
        #1;
        chk_ports("flush.e", 1'b0, 2'd0, 32'h0, 1'b0, 2'd0, 32'h0);
        chk("postflush.ready", 64'(req_ready), 64'b0101);
        tick();
        chk_ports("postflush.e", 1'b1, 2'd0, 32'h1000, 1'b1, 2'd2, 32'h1002);

`ifdef WB_EARLY_WAKE_EN
        // Pointer now 3: scan 3,0,1,2 -> port0=BU? no, ALU1 first, then BU.
        req_valid = 4'b0110;
        req_phy[1*PHY_W +: PHY_W] = 6'd5;
        req_phy[2*PHY_W +: PHY_W] = 6'd7;
        #1;
        chk("ew.ready",  64'(req_ready), 64'b0110);
        chk("ew0.valid", 64'(ew0_valid), 64'd1);
        chk("ew0.phy",   64'(ew0_phy),   64'd5);
        chk("ew1.valid", 64'(ew1_valid), 64'd1);
        chk("ew1.phy",   64'(ew1_phy),   64'd7);
        wb_stall = 1'b1;
        #1;
        chk("ew0.stall", 64'(ew0_valid), 64'd0);
        chk("ew1.stall", 64'(ew1_valid), 64'd0);
        wb_stall = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
